// File: rtl/snitch_pkg.sv
// Shared types for the FP dispatch stage between the FP sequencer and snitch_fpu.
//   fpu_tag_t : routing tag carried with each FPU request and returned with its result
//               {is_int, rsvd, rd[4:0]}
//   fpu_req_t : FPU operation fields passed through from the decoded op
package snitch_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {
        FP32, FP64, FP16, FP8, FP16ALT
    } fp_format_e;

    typedef enum logic [1:0] {
        INT8, INT16, INT32, INT64
    } int_format_e;

    typedef struct packed {
        logic       is_int;
        logic       rsvd;
        logic [4:0] rd;
    } fpu_tag_t;

    typedef struct packed {
        roundmode_e  rnd_mode;
        operation_e  op;
        logic        op_mod;
        fp_format_e  src_fmt;
        fp_format_e  dst_fmt;
        int_format_e int_fmt;
        logic        vectorial_op;
    } fpu_req_t;

endpackage

// File: rtl/snitch_fpu_dispatch.sv
// FP op dispatch: issues decoded FP ops to snitch_fpu, retires tagged results to the
// FP register file or the integer writeback port, scoreboards in-flight FP
// destinations against RAW/WAW hazards, accumulates fflags and supports fences.
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   op_valid_i/op_ready_o, op_i          decoded-op handshake and FPU op fields
//   rs_i, rs_used_i, rd_i, rd_is_int_i   operand/destination registers
//   fence_i                              hold issue until nothing is in flight
//   fpr_raddr_o/fpr_rdata_i              FP RF combinational read
//   fpu_in_valid_o/fpu_in_ready_i        FPU request (operands, req, tag)
//   fpu_out_valid_i/fpu_out_ready_o      FPU response (result, status, tag)
//   fpr_we_o/fpr_waddr_o/fpr_wdata_o     FP RF write port
//   int_wb_*                             integer writeback handshake
//   fflags_o, fflags_clr_i               sticky exception flags and CSR clear
//   busy_o                               ops in flight
module snitch_fpu_dispatch
    import snitch_pkg::*;
#(
    parameter int unsigned FLEN           = 64,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 op_valid_i,
    output logic                 op_ready_o,
    input  fpu_req_t             op_i,
    input  logic [2:0][4:0]      rs_i,
    input  logic [2:0]           rs_used_i,
    input  logic [4:0]           rd_i,
    input  logic                 rd_is_int_i,
    input  logic                 fence_i,
    output logic [2:0][4:0]      fpr_raddr_o,
    input  logic [2:0][FLEN-1:0] fpr_rdata_i,
    output logic                 fpu_in_valid_o,
    input  logic                 fpu_in_ready_i,
    output logic [2:0][FLEN-1:0] fpu_operands_o,
    output fpu_req_t             fpu_req_o,
    output fpu_tag_t             fpu_tag_o,
    input  logic                 fpu_out_valid_i,
    output logic                 fpu_out_ready_o,
    input  logic [FLEN-1:0]      fpu_result_i,
    input  logic [4:0]           fpu_status_i,
    input  fpu_tag_t             fpu_tag_i,
    output logic                 fpr_we_o,
    output logic [4:0]           fpr_waddr_o,
    output logic [FLEN-1:0]      fpr_wdata_o,
    output logic                 int_wb_valid_o,
    input  logic                 int_wb_ready_i,
    output logic [4:0]           int_wb_rd_o,
    output logic [31:0]          int_wb_data_o,
    output logic [4:0]           fflags_o,
    input  logic                 fflags_clr_i,
    output logic                 busy_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {RUN, DRAIN} state_e;

    state_e          state_q;
    logic [31:0]     sb_q, sb_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      fflags_q, fflags_d;
    logic            hazard, stall, issue, retire;

    // ---------------- issue side ----------------
    always_comb begin
        hazard = ~rd_is_int_i & sb_q[rd_i];
        for (int unsigned i = 0; i < 3; i++) begin
            hazard = hazard | (rs_used_i[i] & sb_q[rs_i[i]]);
        end
    end

    // A fence arriving with ops in flight must not let its own op slip out in the
    // cycle before the FSM reaches DRAIN, so it stalls combinationally as well.
    assign stall = hazard
                 | (cnt_q == CntW'(MaxOutstanding))
                 | (state_q == DRAIN)
                 | (fence_i & (cnt_q != '0));

    assign fpu_in_valid_o = op_valid_i & ~stall;
    assign op_ready_o     = fpu_in_ready_i & ~stall;
    assign issue          = op_valid_i & fpu_in_ready_i & ~stall;

    assign fpr_raddr_o    = rs_i;
    assign fpu_operands_o = fpr_rdata_i;
    assign fpu_req_o      = op_i;
    assign fpu_tag_o      = '{is_int: rd_is_int_i, rsvd: 1'b0, rd: rd_i};

    // ---------------- retire side ----------------
    assign fpu_out_ready_o = fpu_tag_i.is_int ? int_wb_ready_i : 1'b1;
    assign retire          = fpu_out_valid_i & fpu_out_ready_o;

    assign fpr_we_o       = fpu_out_valid_i & ~fpu_tag_i.is_int;
    assign fpr_waddr_o    = fpu_tag_i.rd;
    assign fpr_wdata_o    = fpu_result_i;
    assign int_wb_valid_o = fpu_out_valid_i & fpu_tag_i.is_int;
    assign int_wb_rd_o    = fpu_tag_i.rd;
    assign int_wb_data_o  = fpu_result_i[31:0];

    assign fflags_o = fflags_q;
    assign busy_o   = (cnt_q != '0);

    // ---------------- next state ----------------
    always_comb begin
        sb_d = sb_q;
        // Clear before set: a retiring register re-issued in the same cycle stays marked.
        if (retire && !fpu_tag_i.is_int) sb_d[fpu_tag_i.rd] = 1'b0;
        if (issue && !rd_is_int_i)       sb_d[rd_i]         = 1'b1;

        cnt_d = cnt_q + CntW'(issue) - CntW'(retire);

        fflags_d = fflags_q;
        if (fflags_clr_i)  fflags_d = retire ? fpu_status_i : '0;
        else if (retire)   fflags_d = fflags_q | fpu_status_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RUN;
            sb_q     <= '0;
            cnt_q    <= '0;
            fflags_q <= '0;
        end else begin
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            fflags_q <= fflags_d;
            case (state_q)
                RUN:     if (fence_i && cnt_q != '0) state_q <= DRAIN;
                DRAIN:   if (cnt_d == '0)            state_q <= RUN;
                default:                             state_q <= RUN;
            endcase
        end
    end

    // ---------------- checks ----------------
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        retire |-> (cnt_q != '0));
    a_sb_hit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (retire && !fpu_tag_i.is_int) |-> sb_q[fpu_tag_i.rd]);
    a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CntW'(MaxOutstanding));
    a_rsvd_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        retire |-> !fpu_tag_i.rsvd);

endmodule

// File: tb/tb_snitch_fpu_dispatch.sv
`timescale 1ns/1ps
module tb_snitch_fpu_dispatch;
    import snitch_pkg::*;

    localparam int unsigned FLEN  = 64;
    localparam int unsigned MAXO  = 4;
    localparam int unsigned REQ_W = $bits(fpu_req_t);

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 op_valid_i, op_ready_o;
    fpu_req_t             op_i;
    logic [2:0][4:0]      rs_i;
    logic [2:0]           rs_used_i;
    logic [4:0]           rd_i;
    logic                 rd_is_int_i, fence_i;
    logic [2:0][4:0]      fpr_raddr_o;
    logic [2:0][FLEN-1:0] fpr_rdata_i;
    logic                 fpu_in_valid_o, fpu_in_ready_i;
    logic [2:0][FLEN-1:0] fpu_operands_o;
    fpu_req_t             fpu_req_o;
    fpu_tag_t             fpu_tag_o;
    logic                 fpu_out_valid_i, fpu_out_ready_o;
    logic [FLEN-1:0]      fpu_result_i;
    logic [4:0]           fpu_status_i;
    fpu_tag_t             fpu_tag_i;
    logic                 fpr_we_o;
    logic [4:0]           fpr_waddr_o;
    logic [FLEN-1:0]      fpr_wdata_o;
    logic                 int_wb_valid_o, int_wb_ready_i;
    logic [4:0]           int_wb_rd_o;
    logic [31:0]          int_wb_data_o;
    logic [4:0]           fflags_o;
    logic                 fflags_clr_i, busy_o;

    snitch_fpu_dispatch #(.FLEN(FLEN), .MaxOutstanding(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_i(op_i),
        .rs_i(rs_i), .rs_used_i(rs_used_i), .rd_i(rd_i), .rd_is_int_i(rd_is_int_i),
        .fence_i(fence_i), .fpr_raddr_o(fpr_raddr_o), .fpr_rdata_i(fpr_rdata_i),
        .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
        .fpu_operands_o(fpu_operands_o), .fpu_req_o(fpu_req_o), .fpu_tag_o(fpu_tag_o),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
        .fpr_we_o(fpr_we_o), .fpr_waddr_o(fpr_waddr_o), .fpr_wdata_o(fpr_wdata_o),
        .int_wb_valid_o(int_wb_valid_o), .int_wb_ready_i(int_wb_ready_i),
        .int_wb_rd_o(int_wb_rd_o), .int_wb_data_o(int_wb_data_o),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: in-order FPU holding every op issued but not yet retired.
    typedef struct {
        fpu_tag_t        tag;
        logic [FLEN-1:0] res;
        logic [4:0]      st;
        int              due;
    } op_t;

    op_t        fq[$];
    int         cyc = 0;
    bit         m_drain = 1'b0;
    logic [4:0] m_flags = '0;
    int         lat = 1;
    logic [4:0] next_st = '0;
    bit         clr_on_retire = 1'b0;
    int         n_checks = 0, n_fail = 0;

    bit         fired;
    logic       last_we, last_ordy, last_iwv;
    logic [4:0] last_waddr, last_iwrd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present FPU response, check all outputs against the model at
    // the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        bit hz, stall, rsp, is_int, ordy, fire, retire;
        int pre;
        pre = fq.size();
        rsp = (pre != 0) && (cyc >= fq[0].due);
        fpu_out_valid_i = rsp;
        if (rsp) begin
            fpu_tag_i    = fq[0].tag;
            fpu_result_i = fq[0].res;
            fpu_status_i = fq[0].st;
        end else begin
            fpu_tag_i    = '0;
            fpu_result_i = '0;
            fpu_status_i = '0;
        end
        if (clr_on_retire) fflags_clr_i = rsp;
        @(negedge clk_i);

        hz = 1'b0;
        foreach (fq[k]) begin
            if (!fq[k].tag.is_int) begin
                for (int i = 0; i < 3; i++)
                    if (rs_used_i[i] && rs_i[i] == fq[k].tag.rd) hz = 1'b1;
                if (!rd_is_int_i && rd_i == fq[k].tag.rd) hz = 1'b1;
            end
        end
        stall  = hz || pre == MAXO || m_drain || (fence_i && pre != 0);
        is_int = fpu_tag_i.is_int;
        ordy   = is_int ? int_wb_ready_i : 1'b1;
        fire   = op_valid_i && fpu_in_ready_i && !stall;

        chk("in_valid", fpu_in_valid_o, op_valid_i && !stall);
        chk("op_ready", op_ready_o, fpu_in_ready_i && !stall);
        chk("raddr", fpr_raddr_o, rs_i);
        if (fire) begin
            chk("tag", fpu_tag_o, {rd_is_int_i, 1'b0, rd_i});
            chk("req", fpu_req_o, op_i);
            for (int i = 0; i < 3; i++) chk("operand", fpu_operands_o[i], fpr_rdata_i[i]);
        end
        chk("out_ready", fpu_out_ready_o, ordy);
        chk("fpr_we", fpr_we_o, rsp && !is_int);
        if (rsp && !is_int) begin
            chk("fpr_waddr", fpr_waddr_o, fq[0].tag.rd);
            chk("fpr_wdata", fpr_wdata_o, fq[0].res);
        end
        chk("int_wb_valid", int_wb_valid_o, rsp && is_int);
        if (rsp && is_int) begin
            chk("int_wb_rd", int_wb_rd_o, fq[0].tag.rd);
            chk("int_wb_data", int_wb_data_o, fq[0].res[31:0]);
        end
        chk("busy", busy_o, pre != 0);
        chk("fflags", fflags_o, m_flags);

        fired      = op_valid_i && op_ready_o;
        last_we    = fpr_we_o;
        last_waddr = fpr_waddr_o;
        last_ordy  = fpu_out_ready_o;
        last_iwv   = int_wb_valid_o;
        last_iwrd  = int_wb_rd_o;

        @(posedge clk_i);
        retire = rsp && ordy;
        if (retire) begin
            m_flags = fflags_clr_i ? fq[0].st : (m_flags | fq[0].st);
            void'(fq.pop_front());
        end else if (fflags_clr_i) begin
            m_flags = '0;
        end
        if (!m_drain) m_drain = fence_i && pre != 0;
        else if (fq.size() == 0) m_drain = 1'b0;
        if (fire)
            fq.push_back('{tag: '{is_int: rd_is_int_i, rsvd: 1'b0, rd: rd_i},
                           res: {$urandom, $urandom}, st: next_st, due: cyc + lat});
        cyc++;
        #1;
    endtask

    task automatic idle_op();
        op_valid_i = 1'b0;
        rs_used_i  = '0;
        rs_i       = '0;
        fence_i    = 1'b0;
    endtask

    task automatic set_op(input logic [4:0] rd, input bit is_int, input logic [2:0] used,
                          input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        op_valid_i  = 1'b1;
        rd_i        = rd;
        rd_is_int_i = is_int;
        rs_used_i   = used;
        rs_i[0]     = a;
        rs_i[1]     = b;
        rs_i[2]     = c;
        op_i        = fpu_req_t'(REQ_W'($urandom));
        for (int i = 0; i < 3; i++) fpr_rdata_i[i] = {$urandom, $urandom};
    endtask

    task automatic issue_wait(input string tag, output int at);
        int n = 0;
        at = -1;
        while (n < 100) begin
            cycle();
            if (fired) begin
                at = cyc - 1;
                break;
            end
            n++;
        end
        chk(tag, n < 100, 1'b1);
        idle_op();
    endtask

    task automatic drain_all();
        int n = 0;
        idle_op();
        while (fq.size() != 0 && n < 200) begin
            cycle();
            n++;
        end
        chk("drain_bound", n < 200, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, at;
        rst_ni = 1'b0;
        idle_op();
        op_i = '0; rd_i = '0; rd_is_int_i = 1'b0; fpr_rdata_i = '0;
        fpu_in_ready_i = 1'b1; int_wb_ready_i = 1'b1; fflags_clr_i = 1'b0;
        fpu_out_valid_i = 1'b0; fpu_tag_i = '0; fpu_result_i = '0; fpu_status_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_fflags", fflags_o, 5'h00);
        chk("rst_in_valid", fpu_in_valid_o, 1'b0);
        chk("rst_fpr_we", fpr_we_o, 1'b0);
        chk("rst_int_wb_valid", int_wb_valid_o, 1'b0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // fadd f3,f1,f2, latency 3
        lat = 3;
        set_op(5'd3, 1'b0, 3'b011, 5'd1, 5'd2, 5'd0);
        cycle();
        chk("t1_issue", fired, 1'b1);
        idle_op();
        cycle();
        cycle();
        chk("t1_we_early", last_we, 1'b0);
        cycle();
        chk("t1_we", last_we, 1'b1);
        chk("t1_waddr", last_waddr, 5'd3);
        drain_all();

        // fadd f3 then dependent fmul f4,f3,f1
        set_op(5'd3, 1'b0, 3'b011, 5'd1, 5'd2, 5'd0);
        cycle();
        t0 = cyc - 1;
        set_op(5'd4, 1'b0, 3'b011, 5'd3, 5'd1, 5'd0);
        issue_wait("t2_wait", at);
        chk("t2_fmul_issue", at, t0 + 4);
        drain_all();

        // fle.d x5 with integer writeback back-pressured for 4 cycles
        lat = 1;
        int_wb_ready_i = 1'b0;
        set_op(5'd5, 1'b1, 3'b011, 5'd1, 5'd2, 5'd0);
        cycle();
        idle_op();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t3_hold", last_ordy, 1'b0);
        end
        int_wb_ready_i = 1'b1;
        cycle();
        chk("t3_iwv", last_iwv, 1'b1);
        chk("t3_iwrd", last_iwrd, 5'd5);
        chk("t3_no_we", last_we, 1'b0);
        drain_all();

        // outstanding limit: 5 independent ops, FPU slow
        lat = 20;
        set_op(5'd10, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        cycle();
        t0 = cyc - 1;
        for (int r = 11; r < 14; r++) begin
            set_op(5'(r), 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
            cycle();
        end
        set_op(5'd14, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        issue_wait("t4_wait", at);
        chk("t4_fifth_issue", at, t0 + 21);
        drain_all();

        // fence with two in flight, then fence with none
        lat = 6;
        set_op(5'd6, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        cycle();
        t0 = cyc - 1;
        set_op(5'd7, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        cycle();
        set_op(5'd8, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        fence_i = 1'b1;
        issue_wait("t5_wait", at);
        chk("t5_fence_issue", at, t0 + 8);
        drain_all();
        set_op(5'd9, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        fence_i = 1'b1;
        cycle();
        chk("t5_fence_free", fired, 1'b1);
        drain_all();

        // fflags accumulation and clear coincident with a retire
        lat = 1;
        fflags_clr_i = 1'b1;
        cycle();
        fflags_clr_i = 1'b0;
        next_st = 5'h01;
        set_op(5'd1, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        cycle();
        next_st = 5'h10;
        set_op(5'd2, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        cycle();
        drain_all();
        chk("t6_flags_or", fflags_o, 5'h11);
        next_st = 5'h04;
        set_op(5'd3, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        clr_on_retire = 1'b1;
        cycle();
        drain_all();
        clr_on_retire = 1'b0;
        fflags_clr_i  = 1'b0;
        chk("t6_flags_clr", fflags_o, 5'h04);

        // asynchronous reset with ops in flight
        lat = 10;
        set_op(5'd20, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        cycle();
        set_op(5'd21, 1'b1, 3'b000, 5'd0, 5'd0, 5'd0);
        cycle();
        idle_op();
        rst_ni = 1'b0;
        #2;
        chk("t7_busy", busy_o, 1'b0);
        chk("t7_fflags", fflags_o, 5'h00);
        fq.delete();
        m_drain = 1'b0;
        m_flags = '0;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        cycle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            lat     = int'($urandom_range(1, 4));
            next_st = 5'($urandom);
            if ($urandom_range(0, 9) < 7) begin
                logic [2:0] used;
                used = 3'($urandom);
                set_op(5'($urandom), $urandom_range(0, 3) == 0, used,
                       used[0] ? 5'($urandom) : 5'd0,
                       used[1] ? 5'($urandom) : 5'd0,
                       used[2] ? 5'($urandom) : 5'd0);
            end else begin
                idle_op();
            end
            fence_i        = ($urandom_range(0, 19) == 0);
            fpu_in_ready_i = ($urandom_range(0, 4) != 0);
            int_wb_ready_i = ($urandom_range(0, 9) < 7);
            fflags_clr_i   = ($urandom_range(0, 19) == 0);
            cycle();
        end
        fflags_clr_i   = 1'b0;
        fpu_in_ready_i = 1'b1;
        int_wb_ready_i = 1'b1;
        drain_all();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
